// File: rtl/fmarb_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
package fmarb_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIfReq  = 3'd1,
        StIfWait = 3'd2,
        StDReq   = 3'd3,
        StDWait  = 3'd4
    } state_e;

    localparam logic RID_IF = 1'b0;
    localparam logic RID_D  = 1'b1;

endpackage

// File: rtl/fmarb_prio.sv
// Winner select for the shared memory port: data first, unless fetch has been starved
// for STARVE_LIMIT consecutive data wins.
module fmarb_prio
    import fmarb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    input  logic take,
    output logic winner
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] streak_q, streak_d;

    always_comb begin
        winner = (d_req && !(if_req && streak_q == LIMIT)) ? RID_D : RID_IF;
    end

    // Streak only grows while a fetch is actually waiting behind the data win.
    always_comb begin
        streak_d = streak_q;
        if (take) begin
            if (winner == RID_IF) begin
                streak_d = '0;
            end else if (if_req && streak_q != LIMIT) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit, one access
// in flight at a time, discarding fetch responses cancelled by a branch flush.
module fetch_mem_arbiter
    import fmarb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          drop_q, drop_d;
    logic          if_req_eff;
    logic          take;
    logic          winner;

    // A flushing fetch is not a candidate for the port this cycle.
    assign if_req_eff = if_req & ~if_flush;

    fmarb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk   (clk),
        .rst_n (rst_n),
        .if_req(if_req_eff),
        .d_req (d_req),
        .take  (take),
        .winner(winner)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        drop_d    = drop_q;
        take      = 1'b0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_req   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_req_eff || d_req) begin
                    take = 1'b1;
                    if (winner == RID_D) begin
                        d_gnt   = 1'b1;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        state_d = StDReq;
                    end else begin
                        if_gnt  = 1'b1;
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        state_d = StIfReq;
                    end
                end
            end
            StIfReq: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = StIfWait;
                    if (if_flush) drop_d = 1'b1;
                end else if (if_flush) begin
                    state_d = StIdle;
                end
            end
            StIfWait: begin
                if (mem_rvalid) begin
                    if (!drop_q && !if_flush) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                    state_d = StIdle;
                end else if (if_flush) begin
                    drop_d = 1'b1;
                end
            end
            StDReq: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = StDWait;
            end
            StDWait: begin
                if (mem_rvalid) begin
                    d_rvalid = 1'b1;
                    d_rdata  = we_q ? '0 : mem_rdata;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) drop_d = 1'b0;

        // Grants are combinational from the inputs; keep them quiet while reset is held.
        if (!rst_n) begin
            take   = 1'b0;
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end
    end

    assign if_stall  = if_req & ~if_rvalid & rst_n;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, well away from the next edge.
module tb_fetch_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_gnt, if_rvalid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_mem_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        step; step;
        rst_n = 1'b1;
        step;
        // Fetch into IF_WAIT, then reset underneath it.
        if_req = 1; if_addr = 32'h40;
        #1;
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL rst_pre_gnt: got %h want 1", if_gnt);
        else n_pass++;
        step;
        mem_gnt = 1;
        #1;
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_pre_req: got %h want 1", mem_req);
        else n_pass++;
        step;
        mem_gnt = 0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0)
            $display("FAIL rst_mem_out: got %h/%h/%h want 0", mem_req, mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if ({if_gnt, if_rvalid, if_stall, if_rdata, d_gnt, d_rvalid, d_rdata} !== 69'd0)
            $display("FAIL rst_port_out: got %b%b%b %h want 0", if_gnt, if_rvalid, if_stall,
                     if_rdata);
        else n_pass++;
        if_req = 0;
        step;
        rst_n = 1'b1;
        step;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_idle_req: got %h want 0", mem_req);
        else n_pass++;
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h100;
        #1;
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL fetch_gnt: got %h want 1", if_gnt);
        else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL fetch_req0: got %h want 0", mem_req);
        else n_pass++;
        step;
        mem_gnt = 1;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100})
            $display("FAIL fetch_mem: got %h %h %h want 1 0 100", mem_req, mem_we, mem_addr);
        else n_pass++;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL fetch_stall: got %h want 1", if_stall);
        else n_pass++;
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        #1;
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h0050_0093})
            $display("FAIL fetch_rvalid: got %h %h want 1 00500093", if_rvalid, if_rdata);
        else n_pass++;
        n_checks++;
        if ({if_stall, mem_req} !== 2'b00)
            $display("FAIL fetch_stall_clr: got %b%b want 00", if_stall, mem_req);
        else n_pass++;
        step;
        mem_rvalid = 0; if_req = 0;
        step;
    endtask

    task automatic test_data_priority;
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        #1;
        n_checks++;
        if ({d_gnt, if_gnt} !== 2'b10) $display("FAIL prio_gnt: got %b%b want 10", d_gnt, if_gnt);
        else n_pass++;
        step;
        d_req = 0; mem_gnt = 1;
        #1;
        n_checks++; if (mem_addr !== 32'h2000) $display("FAIL prio_daddr: got %h want 2000", mem_addr);
        else n_pass++;
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        #1;
        n_checks++;
        if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, 32'h1111_2222, 1'b0})
            $display("FAIL prio_drdata: got %h %h %h want 1 11112222 0", d_rvalid, d_rdata,
                     if_rvalid);
        else n_pass++;
        n_checks++; if (if_stall !== 1'b1) $display("FAIL prio_stall: got %h want 1", if_stall);
        else n_pass++;
        step;
        mem_rvalid = 0;
        #1;
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL prio_if_gnt: got %h want 1", if_gnt);
        else n_pass++;
        step;
        mem_gnt = 1;
        #1;
        n_checks++; if (mem_addr !== 32'h104) $display("FAIL prio_iaddr: got %h want 104", mem_addr);
        else n_pass++;
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        #1;
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h13})
            $display("FAIL prio_irdata: got %h %h want 1 00000013", if_rvalid, if_rdata);
        else n_pass++;
        step;
        mem_rvalid = 0; if_req = 0;
        step;
    endtask

    task automatic test_starvation;
        logic exp_d, exp_if;
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 0; d_addr = 32'h2400;
        for (int i = 0; i < 5; i++) begin
            exp_d  = (i < 4);
            exp_if = (i == 4);
            #1;
            n_checks++;
            if ({d_gnt, if_gnt} !== {exp_d, exp_if})
                $display("FAIL starve_gnt%0d: got %b%b want %b%b", i, d_gnt, if_gnt, exp_d,
                         exp_if);
            else n_pass++;
            step;
            mem_gnt = 1;
            step;
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA000_0000 + i;
            step;
            mem_rvalid = 0;
        end
        if_req = 0; d_req = 0;
        step;
    endtask

    task automatic test_flush;
        // Flush while idle suppresses the fetch grant.
        if_req = 1; if_flush = 1; if_addr = 32'h180;
        #1;
        n_checks++; if (if_gnt !== 1'b0) $display("FAIL flush_idle_gnt: got %h want 0", if_gnt);
        else n_pass++;
        step;
        if_flush = 0;
        #1;
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL flush_gnt: got %h want 1", if_gnt);
        else n_pass++;
        step;
        if_req = 0; mem_gnt = 1;
        step;
        mem_gnt = 0; if_flush = 1;
        #1;
        n_checks++; if (if_rvalid !== 1'b0) $display("FAIL flush_wait_rv: got %h want 0", if_rvalid);
        else n_pass++;
        step;
        if_flush = 0;
        step;
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        n_checks++;
        if ({if_rvalid, d_rvalid} !== 2'b00)
            $display("FAIL flush_drop: got %b%b want 00", if_rvalid, d_rvalid);
        else n_pass++;
        step;
        mem_rvalid = 0; if_req = 1; if_addr = 32'h200;
        #1;
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL flush_next_gnt: got %h want 1", if_gnt);
        else n_pass++;
        step;
        mem_gnt = 1;
        #1;
        n_checks++; if (mem_addr !== 32'h200) $display("FAIL flush_next_addr: got %h want 200", mem_addr);
        else n_pass++;
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A0_0113;
        #1;
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h00A0_0113})
            $display("FAIL flush_next_data: got %h %h want 1 00a00113", if_rvalid, if_rdata);
        else n_pass++;
        step;
        mem_rvalid = 0; if_req = 0;
        step;
    endtask

    task automatic test_store;
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (d_gnt !== 1'b1) $display("FAIL store_gnt: got %h want 1", d_gnt);
        else n_pass++;
        step;
        // Requester moves on; the captured request must not follow it.
        d_req = 0; d_we = 0; d_addr = 32'h1234; d_wdata = 32'h5678;
        for (int k = 0; k < 4; k++) begin
            mem_gnt = (k == 3);
            #1;
            n_checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF})
                $display("FAIL store_hold%0d: got %h %h %h %h want 1 1 3000 deadbeef", k,
                         mem_req, mem_we, mem_addr, mem_wdata);
            else n_pass++;
            step;
        end
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5555_5555;
        #1;
        n_checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h0})
            $display("FAIL store_done: got %h %h want 1 00000000", d_rvalid, d_rdata);
        else n_pass++;
        step;
        // Stray response while idle must not pulse anything.
        mem_rvalid = 1;
        #1;
        n_checks++;
        if ({if_rvalid, d_rvalid} !== 2'b00)
            $display("FAIL stray_rvalid: got %b%b want 00", if_rvalid, d_rvalid);
        else n_pass++;
        step;
        mem_rvalid = 0;
        step;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_data_priority;
        test_starvation;
        test_flush;
        test_store;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
